// File: rtl/dmem_pkg.sv
// Shared types and defaults for the M-stage data-memory responder.
// Store entries carry a full 30-bit word address so the struct is independent of ADDR_W.
package dmem_pkg;

    localparam int DEF_DEPTH  = 4;
    localparam int DEF_ADDR_W = 10;
    localparam int MAX_ADDR_W = 30;

    typedef enum logic [0:0] {
        IDLE,
        RD_WAIT
    } state_t;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;
        logic [31:0]           data;
    } entry_t;

    function automatic entry_t mk_entry(input logic [MAX_ADDR_W-1:0] addr,
                                        input logic [31:0]           data);
        entry_t e;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/store_buffer.sv
// Posted-write store buffer: circular FIFO with youngest-match associative lookup.
// Callers must never push when full or pop when empty.
module store_buffer
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  entry_t                  push_entry,
    input  logic                    pop,
    input  logic [MAX_ADDR_W-1:0]   lookup_addr,
    output entry_t                  head_entry,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    hit,
    output logic [31:0]             hit_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             entries [DEPTH];
    logic [DEPTH-1:0]   valid;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W-1:0]   idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_W'(1);
            end
            if (push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload storage needs no reset; valid bits gate every read.
    always_ff @(posedge clk) begin
        if (push)
            entries[tail] <= push_entry;
    end

    assign head_entry = entries[head];

    // Walk oldest to youngest so the last match (youngest store) wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (valid[idx] && (entries[idx].addr == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// M-stage data port responder: posted stores drain to a single-port SRAM,
// loads forward from the store buffer or take a one-cycle SRAM read with stall.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memreadM,
    input  logic              memwriteM,
    input  logic [31:0]       aluoutM,
    input  logic [31:0]       writedataM,
    output logic [31:0]       readdataM,
    output logic              stallM,
    output logic              drained,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t             state;
    logic [ADDR_W-1:0]  wa;
    logic               is_store;
    logic               is_load;
    logic               full;
    logic               push;
    logic               load_miss;
    logic               drain;
    logic               hit;
    logic [31:0]        hit_data;
    logic [CNT_W-1:0]   count;
    entry_t             head;
    logic               unused_bits;

    assign wa       = aluoutM[ADDR_W+1:2];
    // Read+write together is illegal upstream; treating it as a store keeps ordering safe.
    assign is_store = memwriteM;
    assign is_load  = memreadM & ~memwriteM;
    assign full     = (count == CNT_W'(DEPTH));
    assign push     = is_store & ~full;

    assign load_miss = (state == IDLE) & is_load & ~hit;
    assign drain     = (state == IDLE) & (count != '0) & ~load_miss;

    store_buffer #(
        .DEPTH (DEPTH)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_entry  (mk_entry(MAX_ADDR_W'(wa), writedataM)),
        .pop         (drain),
        .lookup_addr (MAX_ADDR_W'(wa)),
        .head_entry  (head),
        .count       (count),
        .hit         (hit),
        .hit_data    (hit_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (load_miss) state <= RD_WAIT;
                RD_WAIT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stallM     = load_miss | (is_store & full);
        sram_en    = load_miss | drain;
        sram_we    = drain;
        sram_addr  = load_miss ? wa : head.addr[ADDR_W-1:0];
        sram_wdata = drain ? head.data : '0;
        readdataM  = '0;
        if (state == RD_WAIT)
            readdataM = sram_rdata;
        else if (is_load && hit)
            readdataM = hit_data;
    end

    assign drained = (count == '0) && (state == IDLE);

    assign unused_bits = ^{aluoutM, head.addr};

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a behavioural synchronous SRAM and write log.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        memreadM;
    logic        memwriteM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic [31:0] readdataM;
    logic        stallM;
    logic        drained;
    logic        sram_en;
    logic        sram_we;
    logic [9:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int total = 0;
    int bad   = 0;
    int rd_cnt = 0;

    logic [31:0] mem [0:1023];
    logic [31:0] waddr_q [$];
    logic [31:0] wdata_q [$];

    dmem_responder #(.DEPTH(4), .ADDR_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .memreadM   (memreadM),
        .memwriteM  (memwriteM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .readdataM  (readdataM),
        .stallM     (stallM),
        .drained    (drained),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                mem[sram_addr] <= sram_wdata;
                waddr_q.push_back(32'(sram_addr));
                wdata_q.push_back(sram_wdata);
            end else begin
                sram_rdata <= mem[sram_addr];
                rd_cnt     <= rd_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        memreadM   = rd;
        memwriteM  = wr;
        aluoutM    = a;
        writedataM = d;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int rd0;
        logic [31:0] s_addr [6];
        logic [31:0] s_data [6];
        logic [31:0] s_wa   [6];

        s_addr = '{32'h10C, 32'h100, 32'h100, 32'h108, 32'h110, 32'h114};
        s_wa   = '{32'h43,  32'h40,  32'h40,  32'h42,  32'h44,  32'h45};
        s_data = '{32'h5000_0000, 32'h5111_1111, 32'h5222_2222,
                   32'h5333_3333, 32'h5444_4444, 32'h5555_5555};

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[10'h20] = 32'hDEAD_BEEF;
        sram_rdata  = 32'h0;
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset state
        @(negedge clk);
        chk("rst_stall",   32'(stallM),  32'h0);
        chk("rst_en",      32'(sram_en), 32'h0);
        chk("rst_we",      32'(sram_we), 32'h0);
        chk("rst_rdata",   readdataM,    32'h0);
        chk("rst_drained", 32'(drained), 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        next();

        // Store then forwarded load
        drive(1'b0, 1'b1, 32'h40, 32'h1234_5678);
        @(negedge clk);
        chk("st1_stall", 32'(stallM),  32'h0);
        chk("st1_en",    32'(sram_en), 32'h0);
        next();
        rd0 = rd_cnt;
        drive(1'b1, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        chk("fwd_rdata", readdataM,      32'h1234_5678);
        chk("fwd_stall", 32'(stallM),    32'h0);
        chk("fwd_drain_we",   32'(sram_we),   32'h1);
        chk("fwd_drain_addr", 32'(sram_addr), 32'h10);
        next();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("fwd_drained", 32'(drained), 32'h1);
        chk("fwd_no_read", 32'(rd_cnt),  32'(rd0));
        next();

        // Two stores to one word, then load sees the younger
        base = waddr_q.size();
        drive(1'b0, 1'b1, 32'h40, 32'hAAAA_0001);
        next();
        drive(1'b0, 1'b1, 32'h40, 32'hBBBB_0002);
        next();
        drive(1'b1, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        chk("raw_rdata", readdataM, 32'hBBBB_0002);
        next();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        next();
        next();
        chk("raw_nwr",   32'(waddr_q.size() - base), 32'h2);
        chk("raw_a0",    waddr_q[base],   32'h10);
        chk("raw_d0",    wdata_q[base],   32'hAAAA_0001);
        chk("raw_a1",    waddr_q[base+1], 32'h10);
        chk("raw_d1",    wdata_q[base+1], 32'hBBBB_0002);

        // Load miss on empty buffer
        drive(1'b1, 1'b0, 32'h80, 32'h0);
        @(negedge clk);
        chk("miss_en",    32'(sram_en),   32'h1);
        chk("miss_we",    32'(sram_we),   32'h0);
        chk("miss_addr",  32'(sram_addr), 32'h20);
        chk("miss_stall", 32'(stallM),    32'h1);
        chk("miss_rd0",   readdataM,      32'h0);
        next();
        @(negedge clk);
        chk("miss_rdata", readdataM,    32'hDEAD_BEEF);
        chk("miss_stall1", 32'(stallM), 32'h0);
        chk("miss_en1",   32'(sram_en), 32'h0);
        next();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        next();

        // Fill to DEPTH using load misses to hold the port, then overflow
        base = waddr_q.size();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                drive(1'b1, 1'b0, 32'h80, 32'h0);
                next();
            end
            drive(1'b0, 1'b1, s_addr[k], s_data[k]);
            @(negedge clk);
            if (k > 0) chk("fill_no_drain", 32'(sram_en), 32'h0);
            next();
        end
        drive(1'b1, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        chk("young_rdata", readdataM,      32'h5222_2222);
        chk("young_stall", 32'(stallM),    32'h0);
        chk("young_drain", 32'(sram_we),   32'h1);
        chk("young_daddr", 32'(sram_addr), 32'h43);
        next();
        drive(1'b1, 1'b0, 32'h80, 32'h0);
        @(negedge clk);
        chk("fill_miss_we", 32'(sram_we), 32'h0);
        next();
        drive(1'b0, 1'b1, s_addr[4], s_data[4]);
        @(negedge clk);
        chk("fill_rdwait_en", 32'(sram_en), 32'h0);
        chk("fill_rdwait_st", 32'(stallM),  32'h0);
        next();
        drive(1'b0, 1'b1, s_addr[5], s_data[5]);
        @(negedge clk);
        chk("full_stall", 32'(stallM),  32'h1);
        chk("full_drain", 32'(sram_we), 32'h1);
        next();
        @(negedge clk);
        chk("full_accept", 32'(stallM), 32'h0);
        next();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("full_notdrained", 32'(drained), 32'h0);
        next();
        next();
        next();
        @(negedge clk);
        chk("full_drained", 32'(drained), 32'h1);
        chk("full_nwr", 32'(waddr_q.size() - base), 32'h6);
        for (int k = 0; k < 6; k++) begin
            if (base + k < waddr_q.size()) begin
                chk("order_addr", waddr_q[base+k], s_wa[k]);
                chk("order_data", wdata_q[base+k], s_data[k]);
            end
        end
        next();

        // Load miss with a pending store: read owns the port for two cycles
        drive(1'b0, 1'b1, 32'h200, 32'h7777_0000);
        next();
        drive(1'b1, 1'b0, 32'h80, 32'h0);
        @(negedge clk);
        chk("pend_miss_we",  32'(sram_we), 32'h0);
        chk("pend_miss_en",  32'(sram_en), 32'h1);
        chk("pend_drained",  32'(drained), 32'h0);
        next();
        @(negedge clk);
        chk("pend_rdw_en",   32'(sram_en), 32'h0);
        chk("pend_rdw_data", readdataM,    32'hDEAD_BEEF);
        next();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("pend_drain_we",   32'(sram_we),    32'h1);
        chk("pend_drain_addr", 32'(sram_addr),  32'h80);
        chk("pend_drain_data", sram_wdata,      32'h7777_0000);
        next();
        @(negedge clk);
        chk("pend_drained1", 32'(drained), 32'h1);
        chk("pend_idle_en",  32'(sram_en), 32'h0);
        next();

        // Reset mid-drain with three entries queued
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                drive(1'b1, 1'b0, 32'h80, 32'h0);
                next();
            end
            drive(1'b0, 1'b1, 32'h300 + 32'(k * 4), 32'hC000_0000 + 32'(k));
            next();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rm_drain_we",   32'(sram_we),   32'h1);
        chk("rm_drain_addr", 32'(sram_addr), 32'hC0);
        base = waddr_q.size();
        rst = 1'b0;
        #1;
        chk("rm_stall",   32'(stallM),  32'h0);
        chk("rm_en",      32'(sram_en), 32'h0);
        chk("rm_drained", 32'(drained), 32'h1);
        next();
        next();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) next();
        @(negedge clk);
        chk("rm_no_write", 32'(waddr_q.size() - base), 32'h0);
        chk("rm_drained2", 32'(drained), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
